// File: rtl/idct_block_writer_pkg.sv
// Shared definitions for the IDCT block writer: FSM states, SRAM segment layout
// and plane codes (segment layout is also what the colourspace stage reads).
package idct_block_writer_pkg;

   typedef enum logic [1:0] {
      S_W_IDLE,
      S_W_FETCH,
      S_W_FLUSH
   } writer_state_t;

   localparam logic [17:0] Y_BASE    = 18'd0;
   localparam logic [17:0] U_BASE    = 18'd38400;
   localparam logic [17:0] V_BASE    = 18'd57600;
   localparam logic [7:0]  Y_STRIDE  = 8'd160;
   localparam logic [7:0]  UV_STRIDE = 8'd80;

   localparam logic [1:0] PLANE_Y       = 2'd0;
   localparam logic [1:0] PLANE_U       = 2'd1;
   localparam logic [1:0] PLANE_V       = 2'd2;
   localparam logic [1:0] PLANE_INVALID = 2'd3;

   localparam logic [4:0] MAX_BLOCK_ROW = 5'd29;
   localparam logic [5:0] MAX_Y_COL     = 6'd39;
   localparam logic [5:0] MAX_UV_COL    = 6'd19;

endpackage

// File: rtl/idct_block_writer_clip.sv
// Saturates a signed 32-bit IDCT sample into the unsigned 8-bit pixel range.
module clip_s32_u8 (
   input  logic signed [31:0] i_value,
   output logic        [7:0]  o_pixel
);

   always_comb begin
      if (i_value < 32'sd0)
         o_pixel = 8'd0;
      else if (i_value > 32'sd255)
         o_pixel = 8'd255;
      else
         o_pixel = i_value[7:0];
   end

endmodule

// File: rtl/idct_block_writer.sv
// Reads one 8x8 block of S values from the IDCT RAM, clips them to 8 bits and
// writes them as 32 packed pixel pairs into the Y/U/V segment of external SRAM.
module idct_block_writer
   import idct_block_writer_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [1:0]  i_plane,
   input  logic [4:0]  i_block_row,
   input  logic [5:0]  i_block_col,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [5:0]  o_ram_address,
   input  logic [31:0] i_ram_read_data,
   output logic [17:0] o_sram_address,
   output logic [15:0] o_sram_write_data,
   output logic        o_sram_we_n
);

   writer_state_t r_state;
   writer_state_t w_nextState;

   logic [1:0]  r_plane;
   logic [4:0]  r_row;
   logic [5:0]  r_col;
   logic [6:0]  r_cycle;
   logic [7:0]  r_evenPixel;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [5:0]  r_ramAddress;
   logic [17:0] r_sramAddress;
   logic [15:0] r_sramWriteData;
   logic        r_sramWeN;

   logic [5:0]  w_colLimit;
   logic        w_inputsOk;
   logic        w_accept;
   logic        w_reject;
   logic [6:0]  w_kFull;
   logic [5:0]  w_k;
   logic        w_dataValid;
   logic        w_writeNow;
   logic        w_lastWrite;
   logic [7:0]  w_clipped;
   logic [17:0] w_base;
   logic [17:0] w_stride;
   logic [17:0] w_lineIdx;
   logic [17:0] w_dest;

   clip_s32_u8 u_clip (
      .i_value (i_ram_read_data),
      .o_pixel (w_clipped)
   );

   always_comb begin
      w_colLimit = (i_plane == PLANE_Y) ? MAX_Y_COL : MAX_UV_COL;
      w_inputsOk = (i_plane != PLANE_INVALID) && (i_block_row <= MAX_BLOCK_ROW)
                   && (i_block_col <= w_colLimit);
   end

   // r_cycle counts FETCH edges; RAM latency means the data on the bus belongs to index r_cycle-1
   always_comb begin
      w_kFull     = r_cycle - 7'd1;
      w_k         = w_kFull[5:0];
      w_dataValid = (r_state == S_W_FETCH) && (r_cycle != 7'd0);
      w_writeNow  = w_dataValid && w_k[0];
      w_lastWrite = w_writeNow && (w_k == 6'd63);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= S_W_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
      case (r_state)
         S_W_IDLE: begin
            if (i_start) begin
               if (w_inputsOk) begin
                  w_accept    = 1'b1;
                  w_nextState = S_W_FETCH;
               end else begin
                  w_reject = 1'b1;
               end
            end
         end
         S_W_FETCH: begin
            if (w_lastWrite)
               w_nextState = S_W_FLUSH;
         end
         S_W_FLUSH: begin
            w_nextState = S_W_IDLE;
         end
         default: begin
            w_nextState = S_W_IDLE;
         end
      endcase
   end

   always_comb begin
      case (r_plane)
         PLANE_U: begin
            w_base   = U_BASE;
            w_stride = {10'd0, UV_STRIDE};
         end
         PLANE_V: begin
            w_base   = V_BASE;
            w_stride = {10'd0, UV_STRIDE};
         end
         default: begin
            w_base   = Y_BASE;
            w_stride = {10'd0, Y_STRIDE};
         end
      endcase
      w_lineIdx = {10'd0, r_row, 3'b000} + {15'd0, w_k[5:3]};
      w_dest    = w_base + w_lineIdx * w_stride + {10'd0, r_col, 2'b00} + {16'd0, w_k[2:1]};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_plane         <= PLANE_Y;
         r_row           <= 5'd0;
         r_col           <= 6'd0;
         r_cycle         <= 7'd0;
         r_evenPixel     <= 8'd0;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_err           <= 1'b0;
         r_ramAddress    <= 6'd0;
         r_sramAddress   <= 18'd0;
         r_sramWriteData <= 16'd0;
         r_sramWeN       <= 1'b1;
      end else begin
         r_done <= 1'b0;
         r_err  <= w_reject;
         if (w_accept) begin
            r_plane      <= i_plane;
            r_row        <= i_block_row;
            r_col        <= i_block_col;
            r_cycle      <= 7'd0;
            r_busy       <= 1'b1;
            r_ramAddress <= 6'd0;
         end
         if (r_state == S_W_FETCH) begin
            r_cycle   <= r_cycle + 7'd1;
            r_sramWeN <= 1'b1;
            if (r_ramAddress != 6'd63)
               r_ramAddress <= r_ramAddress + 6'd1;
            if (w_dataValid && !w_k[0])
               r_evenPixel <= w_clipped;
            if (w_writeNow) begin
               r_sramWeN       <= 1'b0;
               r_sramWriteData <= {r_evenPixel, w_clipped};
               r_sramAddress   <= w_dest;
            end
         end
         if (r_state == S_W_FLUSH) begin
            r_sramWeN <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
         end
      end
   end

   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_err             = r_err;
   assign o_ram_address     = r_ramAddress;
   assign o_sram_address    = r_sramAddress;
   assign o_sram_write_data = r_sramWriteData;
   assign o_sram_we_n       = r_sramWeN;

endmodule

// File: tb/tb_idct_block_writer.sv
// Self-checking bench for idct_block_writer: table of block requests plus
// hand-written sequences, with an SRAM-write scoreboard fed by a behavioural model.
module tb_idct_block_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  plane;
   logic [4:0]  blockRow;
   logic [5:0]  blockCol;
   logic        busy;
   logic        done;
   logic        err;
   logic [5:0]  ramAddress;
   logic [31:0] ramReadData;
   logic [17:0] sramAddress;
   logic [15:0] sramWriteData;
   logic        sramWeN;

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
      int          wrEdge;
   } wr_t;

   typedef struct {
      string      name;
      logic [1:0] plane;
      logic [4:0] row;
      logic [5:0] col;
      int         pattern;
      bit         expErr;
      int         firstAddr;
      int         lastAddr;
      int         firstWord;
      int         lastWord;
   } vec_t;

   int   mem [64];
   wr_t  sbQ [$];
   wr_t  expWr;
   vec_t vecs [7];

   int checks = 0;
   int failures = 0;
   int edgeCount = 0;
   int writesSeen = 0;
   int errPulses = 0;
   int firstAddr, lastAddr, firstWord, lastWord;

   idct_block_writer dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_plane           (plane),
      .i_block_row       (blockRow),
      .i_block_col       (blockCol),
      .o_busy            (busy),
      .o_done            (done),
      .o_err             (err),
      .o_ram_address     (ramAddress),
      .i_ram_read_data   (ramReadData),
      .o_sram_address    (sramAddress),
      .o_sram_write_data (sramWriteData),
      .o_sram_we_n       (sramWeN)
   );

   always #10 clk = ~clk;

   // Synchronous-read S RAM: data for an address appears one edge after it is sampled
   always @(posedge clk) ramReadData <= mem[ramAddress];

   always @(posedge clk) edgeCount++;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeCount);
      end
   endtask

   function automatic int clipModel(input int s);
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   function automatic int destModel(input int p, input int r, input int c, input int k);
      int base;
      int stride;
      base   = (p == 0) ? 0 : ((p == 1) ? 38400 : 57600);
      stride = (p == 0) ? 160 : 80;
      return base + (r * 8 + k / 8) * stride + c * 4 + (k % 8) / 2;
   endfunction

   function automatic bit validModel(input int p, input int r, input int c);
      return (p != 3) && (r <= 29) && (c <= ((p == 0) ? 39 : 19));
   endfunction

   task automatic loadPattern(input int pat);
      for (int k = 0; k < 64; k++) begin
         case (pat)
            0:       mem[k] = k;
            1:       mem[k] = -5;
            2:       mem[k] = (k % 2 == 0) ? 300 : 128;
            default: mem[k] = int'($urandom_range(0, 1000)) - 400;
         endcase
      end
      if (pat == 3) begin
         mem[5]  = 32'sh7FFFFFFF;
         mem[6]  = 32'sh80000000;
         mem[7]  = 255;
         mem[8]  = 256;
         mem[9]  = 0;
         mem[10] = -1;
      end
   endtask

   // Caller must already sit at a negedge; Start is sampled at the following posedge (E0)
   task automatic applyStimulus(input int p, input int r, input int c, input int pat, output int e0);
      wr_t rec;
      loadPattern(pat);
      writesSeen = 0;
      plane    = 2'(p);
      blockRow = 5'(r);
      blockCol = 6'(c);
      start    = 1'b1;
      e0 = edgeCount + 1;
      if (validModel(p, r, c)) begin
         for (int w = 0; w < 32; w++) begin
            rec.addr   = 18'(destModel(p, r, c, 2 * w));
            rec.data   = 16'((clipModel(mem[2 * w]) << 8) | clipModel(mem[2 * w + 1]));
            rec.wrEdge = e0 + 2 * w + 3;
            sbQ.push_back(rec);
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, input int e0);
      int busyDrops;
      bit seen;
      busyDrops = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (!busy) busyDrops++;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout: got no done within 200 cycles, required done at E0+66", name);
      end else begin
         checkOutput({name, "_done_edge"}, edgeCount - e0, 66);
         checkOutput({name, "_busy_low_at_done"}, busy, 0);
      end
      checkOutput({name, "_busy_drops"}, busyDrops, 0);
      checkOutput({name, "_writes"}, writesSeen, 32);
      checkOutput({name, "_sb_left"}, sbQ.size(), 0);
   endtask

   // SRAM-side monitor: every write must match the next scoreboard entry in address, data and edge
   always @(negedge clk) begin
      if (!rst) begin
         if (sramWeN === 1'b0) begin
            writesSeen++;
            if (writesSeen == 1) begin
               firstAddr = int'(sramAddress);
               firstWord = int'(sramWriteData);
            end
            lastAddr = int'(sramAddress);
            lastWord = int'(sramWriteData);
            if (sbQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", sramAddress, sramWriteData);
            end else begin
               expWr = sbQ.pop_front();
               checkOutput("sram_addr", sramAddress, expWr.addr);
               checkOutput("sram_data", sramWriteData, expWr.data);
               checkOutput("write_edge", edgeCount, expWr.wrEdge);
            end
         end
         if (err) errPulses++;
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int e0;
      int e1;
      int errBefore;
      int prevDone;
      int seenAtReset;

      vecs[0] = '{"y_r0_c0",    2'd0, 5'd0,  6'd0,  0, 1'b0, 0,     1123,  16'h0001, 16'h3E3F};
      vecs[1] = '{"u_r29_c19",  2'd1, 5'd29, 6'd19, 1, 1'b0, 57036, 57599, 16'h0000, 16'h0000};
      vecs[2] = '{"v_r2_c3",    2'd2, 5'd2,  6'd3,  2, 1'b0, 58892, 59455, 16'hFF80, 16'hFF80};
      vecs[3] = '{"y_r29_c39",  2'd0, 5'd29, 6'd39, 0, 1'b0, 37276, 38399, 16'h0001, 16'h3E3F};
      vecs[4] = '{"u_col20",    2'd1, 5'd0,  6'd20, 0, 1'b1, 0, 0, 0, 0};
      vecs[5] = '{"plane3",     2'd3, 5'd0,  6'd0,  0, 1'b1, 0, 0, 0, 0};
      vecs[6] = '{"y_row30",    2'd0, 5'd30, 6'd0,  0, 1'b1, 0, 0, 0, 0};

      rst      = 1'b0;
      start    = 1'b0;
      plane    = 2'd0;
      blockRow = 5'd0;
      blockCol = 6'd0;
      loadPattern(0);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_ram_addr", ramAddress, 0);
      checkOutput("reset_sram_addr", sramAddress, 0);
      checkOutput("reset_sram_data", sramWriteData, 0);
      checkOutput("reset_we_n", sramWeN, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         @(negedge clk);
         errBefore = errPulses;
         applyStimulus(vecs[v].plane, vecs[v].row, vecs[v].col, vecs[v].pattern, e0);
         if (vecs[v].expErr) begin
            checkOutput({vecs[v].name, "_err_now"}, err, 1);
            checkOutput({vecs[v].name, "_busy"}, busy, 0);
            repeat (6) @(negedge clk);
            checkOutput({vecs[v].name, "_err_pulses"}, errPulses - errBefore, 1);
            checkOutput({vecs[v].name, "_writes"}, writesSeen, 0);
            checkOutput({vecs[v].name, "_busy_later"}, busy, 0);
         end else begin
            checkOutput({vecs[v].name, "_busy_e0"}, busy, 1);
            waitDone(vecs[v].name, e0);
            checkOutput({vecs[v].name, "_first_addr"}, firstAddr, vecs[v].firstAddr);
            checkOutput({vecs[v].name, "_last_addr"}, lastAddr, vecs[v].lastAddr);
            checkOutput({vecs[v].name, "_first_word"}, firstWord, vecs[v].firstWord);
            checkOutput({vecs[v].name, "_last_word"}, lastWord, vecs[v].lastWord);
            checkOutput({vecs[v].name, "_no_err"}, errPulses - errBefore, 0);
         end
      end

      // Starts during a transfer are ignored; a Start alongside Done chains the next block
      @(negedge clk);
      errBefore = errPulses;
      applyStimulus(0, 1, 2, 0, e0);
      repeat (9) @(negedge clk);
      plane = 2'd2; blockRow = 5'd5; blockCol = 6'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      plane = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone("ignored_start", e0);
      checkOutput("ignored_start_no_err", errPulses - errBefore, 0);
      prevDone = edgeCount;
      applyStimulus(2, 0, 19, 3, e1);
      checkOutput("b2b_start_edge", e1 - prevDone, 1);
      waitDone("b2b", e1);

      // Reset in the middle of a transfer aborts it immediately
      @(negedge clk);
      applyStimulus(1, 3, 4, 2, e0);
      for (int i = 0; i < 100 && edgeCount < e0 + 29; i++) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_we_n", sramWeN, 1);
      checkOutput("abort_writes", writesSeen, 14);
      seenAtReset = writesSeen;
      sbQ.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("post_abort_busy", busy, 0);
      checkOutput("post_abort_idle_writes", writesSeen, seenAtReset);
      @(negedge clk);
      applyStimulus(1, 3, 4, 2, e0);
      waitDone("after_reset", e0);
      checkOutput("after_reset_first_addr", firstAddr, 38400 + 24 * 80 + 16);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
